data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised data memory for the RV32 core's load/store path. Accepts byte-addressed
//  LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake and stores data in
//  byte-lane banks with per-byte write enables. Returns sign/zero-extended load data one
//  cycle later. Flags misaligned and out-of-range accesses instead of corrupting memory.
// PARAMETERS
//  ADDR_WIDTH  14  byte-address width; depth = 2**(ADDR_WIDTH-2) words
//  DATA_WIDTH  32  word width; must be 32 (RV32), lanes = DATA_WIDTH/8
//  MEM_WORDS   4096  implemented words; word index >= MEM_WORDS -> range error
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid && req_ready
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  req_addr    in   ADDR_WIDTH  byte address
//  req_wdata   in   32  store data, right-aligned (low bytes significant)
//  resp_valid  out  1   response present
//  resp_ready  in   1   response consumed when resp_valid && resp_ready
//  resp_rdata  out  32  load result, extended; 0 for stores and errors
//  resp_err    out  1   misaligned / out-of-range / illegal size
// BEHAVIOUR
//  - Reset (async assert, sync release): resp_valid=0, resp_rdata=0, resp_err=0,
//    req_ready=1; any pending response discarded. Memory contents not reset.
//  - req_ready = !resp_valid || resp_ready (one outstanding response max).
//  - Accept cycle N -> resp_valid at N+1; every accepted request yields exactly one response.
//  - Response held stable (data, err) while resp_valid && !resp_ready.
//  - Back-to-back: resp consumed and new req accepted in same cycle -> next resp at N+1.
//  - Lane select: byte_off=addr[1:0], word=addr[ADDR_WIDTH-1:2].
//  - Store byte enables: B -> 1<<off; H -> 0011<<off; W -> 1111. wdata replicated to lanes.
//  - Load extract: shift word right by 8*off, then B/H sign-extend, BU/HU zero-extend, W pass.
//  - Errors: H/HU with addr[0]=1; W with addr[1:0]!=0; word>=MEM_WORDS; size illegal
//    (incl. 100/101 with req_we=1). On error: no write, resp_err=1, resp_rdata=0.
//  - Store then load same address in next accepted cycle returns new data (write
//    completes at accept edge; load reads array at its own accept edge).
//  - Read port registered: array read only on accepted load; output regs change only on
//    accept (loaded) or reset; no state change when req_valid=0.
//  - Reset asserted mid-store: write at that edge not guaranteed; no response issued.
// STRUCTURE
//  - mem_pkg: mem_size_e enum (MEM_B=3'b000, MEM_H, MEM_W, MEM_BU=3'b100, MEM_HU),
//    function be_of(size, off), function load_ext(word, size, off).
//  - Sub-module dmem_bank (one byte lane: 8-bit x MEM_WORDS, we, addr, wdata, re, rdata),
//    instantiated DATA_WIDTH/8 times via generate.
//  - Top: handshake/response-hold regs, error decode, byte-enable gen, load extension.
// TESTING
//  - SW 0xDEADBEEF @0x10, LW @0x10 -> resp_rdata=0xDEADBEEF, err=0, resp one cycle after accept.
//  - SB 0x80 @0x13, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//  - SH 0x1234 @0x22, LH @0x22 -> 0x00001234; LH @0x21 -> err=1, rdata=0; SW @0x22 -> err=1,
//    then LW @0x20 shows word unchanged.
//  - Hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, resp stable, no accept;
//    release -> each queued request answered in order, no loss/duplication.
//  - Access word index MEM_WORDS (addr=4*MEM_WORDS) -> err=1; size=3'b011 -> err=1; memory untouched.
//  - Assert rst_n=0 with resp_valid=1 -> resp_valid=0 immediately (async); after release
//    req_ready=1 and earlier stored data still readable.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared load/store size encodings and lane helpers for the RV32 data memory.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  function automatic logic [3:0] be_of(input logic [2:0] size, input logic [1:0] off);
    case (size)
      MEM_B, MEM_BU: be_of = 4'b0001 << off;
      MEM_H, MEM_HU: be_of = 4'b0011 << off;
      default:       be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] size,
                                           input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_B:   load_ext = {{24{sh[7]}}, sh[7:0]};
      MEM_H:   load_ext = {{16{sh[15]}}, sh[15:0]};
      MEM_BU:  load_ext = {24'b0, sh[7:0]};
      MEM_HU:  load_ext = {16'b0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous write, registered read on demand.
module dmem_bank #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 load/store data memory: valid/ready request, single outstanding response,
// byte-lane banks, sign/zero-extended loads, error flagging without side effects.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int LANES   = DATA_WIDTH / 8;
  localparam int BANK_AW = $clog2(MEM_WORDS);

  logic                  accept;
  logic [1:0]            off;
  logic [ADDR_WIDTH-3:0] word;
  logic                  size_ok;
  logic                  align_ok;
  logic                  range_ok;
  logic                  req_err;
  logic [3:0]            be;
  logic [31:0]           wdata_rep;
  logic [31:0]           bank_rdata;

  logic                  rd_load;
  logic [2:0]            size_q;
  logic [1:0]            off_q;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[1:0];
  assign word      = req_addr[ADDR_WIDTH-1:2];
  assign range_ok  = 32'(word) < 32'(MEM_WORDS);
  assign req_err   = !size_ok || !align_ok || !range_ok;
  assign be        = be_of(req_size, off);

  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b1;
    case (req_size)
      MEM_B:  size_ok = 1'b1;
      MEM_H:  begin size_ok = 1'b1;    align_ok = !off[0];      end
      MEM_W:  begin size_ok = 1'b1;    align_ok = (off == 2'b00); end
      // Unsigned sizes only make sense for loads
      MEM_BU: size_ok = !req_we;
      MEM_HU: begin size_ok = !req_we; align_ok = !off[0];      end
      default: size_ok = 1'b0;
    endcase
  end

  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      MEM_B:   wdata_rep = {4{req_wdata[7:0]}};
      MEM_H:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dmem_bank #(
      .WORDS(MEM_WORDS),
      .AW   (BANK_AW)
    ) u_bank (
      .clk  (clk),
      .we   (accept && req_we && !req_err && be[i]),
      .re   (accept && !req_we && !req_err),
      .addr (word[BANK_AW-1:0]),
      .wdata(wdata_rep[8*i +: 8]),
      .rdata(bank_rdata[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_load    <= 1'b0;
      size_q     <= MEM_W;
      off_q      <= 2'b00;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= req_err;
      rd_load    <= !req_we && !req_err;
      size_q     <= req_size;
      off_q      <= off;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Bank outputs only move on an accepted load, so extending here keeps the response stable
  assign resp_rdata = rd_load ? load_ext(bank_rdata, size_q, off_q) : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stimulus pushes expected responses, a monitor pops and compares.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam int AW    = 14;
  localparam int WORDS = 1024;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  data_mem_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input bit we, input logic [2:0] sz, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input bit eerr,
                       input bit rr = 1'b1);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = rr;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
    end else begin
      e.rd  = erd;
      e.err = eerr;
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
  endtask

  // Monitor: compares the head expectation while a response is presented, pops on handshake
  initial begin : monitor
    bit pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb[0];
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          if (!pending) chk("resp_latency", 32'(cyc), 32'(e.acc + 1));
          if (resp_ready) begin
            void'(sb.pop_front());
            pending = 1'b0;
          end else begin
            pending = 1'b1;
          end
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    #3;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(1, MEM_W,  14'h010, 32'hDEADBEEF, 32'h0,        0);
    issue(0, MEM_W,  14'h010, 32'h0,        32'hDEADBEEF, 0);
    issue(1, MEM_B,  14'h013, 32'h00000080, 32'h0,        0);
    issue(0, MEM_B,  14'h013, 32'h0,        32'hFFFFFF80, 0);
    issue(0, MEM_BU, 14'h013, 32'h0,        32'h00000080, 0);
    issue(0, MEM_W,  14'h010, 32'h0,        32'h80ADBEEF, 0);
    issue(1, MEM_W,  14'h020, 32'h55667788, 32'h0,        0);
    issue(1, MEM_H,  14'h022, 32'h00AB1234, 32'h0,        0);
    issue(0, MEM_H,  14'h022, 32'h0,        32'h00001234, 0);
    issue(0, MEM_H,  14'h021, 32'h0,        32'h0,        1);
    issue(1, MEM_W,  14'h022, 32'hFFFFFFFF, 32'h0,        1);
    issue(0, MEM_W,  14'h020, 32'h0,        32'h12347788, 0);
    issue(1, MEM_H,  14'h020, 32'h00008001, 32'h0,        0);
    issue(0, MEM_H,  14'h020, 32'h0,        32'hFFFF8001, 0);
    issue(0, MEM_HU, 14'h020, 32'h0,        32'h00008001, 0);
    issue(0, MEM_B,  14'h021, 32'h0,        32'hFFFFFF80, 0);
    issue(0, MEM_BU, 14'h022, 32'h0,        32'h00000034, 0);
    issue(0, MEM_HU, 14'h023, 32'h0,        32'h0,        1);
    // Range and illegal-size accesses must leave memory untouched
    issue(1, MEM_W,  14'h000, 32'h11111111, 32'h0,        0);
    issue(1, MEM_W,  14'hFFC, 32'hCAFEF00D, 32'h0,        0);
    issue(1, MEM_W,  14'h1000, 32'h99999999, 32'h0,       1);
    issue(0, MEM_W,  14'h1000, 32'h0,       32'h0,        1);
    issue(1, 3'b011, 14'h010, 32'h77777777, 32'h0,        1);
    issue(1, MEM_BU, 14'h010, 32'h00000066, 32'h0,        1);
    issue(0, 3'b111, 14'h010, 32'h0,        32'h0,        1);
    issue(0, MEM_W,  14'h000, 32'h0,        32'h11111111, 0);
    issue(0, MEM_W,  14'hFFC, 32'h0,        32'hCAFEF00D, 0);
    issue(0, MEM_W,  14'h010, 32'h0,        32'h80ADBEEF, 0);
    idle();
    repeat (3) @(negedge clk);

    // Backpressure: response held, next request stalls, then both drain in order
    issue(0, MEM_W, 14'h020, 32'h0, 32'h12348001, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = MEM_BU;
      req_addr  = 14'h013;
      #1;
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    issue(0, MEM_BU, 14'h013, 32'h0, 32'h00000080, 0);
    issue(0, MEM_W,  14'h000, 32'h0, 32'h11111111, 0);
    issue(0, MEM_H,  14'h022, 32'h0, 32'h00001234, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    // Async reset with a response pending drops it
    issue(0, MEM_W, 14'h010, 32'h0, 32'h80ADBEEF, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(resp_valid), 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    chk("async_rst_err", 32'(resp_err), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    issue(0, MEM_W, 14'h010, 32'h0, 32'h80ADBEEF, 0);
    issue(0, MEM_W, 14'hFFC, 32'h0, 32'hCAFEF00D, 0);
    idle();
    repeat (4) @(negedge clk);
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
